data_bus: RTL and testbench



---
 rtl/data_bus_pkg.sv | 17 +
 rtl/data_bus_seg7_scan.sv | 28 ++
 rtl/data_bus.sv | 90 +++++++++
 tb/tb_data_bus.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/data_bus_pkg.sv
// data_bus_pkg: address map, TCON bit indices and seven-segment decode table
package data_bus_pkg;
  localparam logic [31:0] ADDR_TH      = 32'h4000_0000;
  localparam logic [31:0] ADDR_TL      = 32'h4000_0004;
  localparam logic [31:0] ADDR_TCON    = 32'h4000_0008;
  localparam logic [31:0] ADDR_LED     = 32'h4000_000C;
  localparam logic [31:0] ADDR_DIGITS  = 32'h4000_0010;
  localparam logic [31:0] ADDR_SYSTICK = 32'h4000_0014;
  localparam int TCON_EN = 0;
  localparam int TCON_IE = 1;
  localparam int TCON_IS = 2;
  // Active-low {dp,g,f,e,d,c,b,a}; entry n is the glyph for hex digit n
  localparam logic [15:0][7:0] SEG7_LUT = {
    8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
    8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };
endpackage

// File: rtl/data_bus_seg7_scan.sv
// seg7_scan: time-multiplexes four hex digits onto one active-low seven-segment display
module seg7_scan
  import data_bus_pkg::*;
#(
  parameter int SCAN_DIV = 100000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] digits,
  output logic [3:0]  an,
  output logic [7:0]  seg
);
  localparam int CW = $clog2(SCAN_DIV);
  logic [CW-1:0] cnt_q;
  logic [1:0]    idx_q;
  logic          wrap;
  assign wrap = cnt_q == CW'(SCAN_DIV - 1);
  always_ff @(posedge clk)
    if (reset) begin
      cnt_q <= '0;
      idx_q <= '0;
    end else begin
      cnt_q <= wrap ? '0 : cnt_q + 1'b1;
      idx_q <= wrap ? idx_q + 1'b1 : idx_q;
    end
  assign an  = ~(4'b0001 << idx_q);
  assign seg = SEG7_LUT[digits[{idx_q, 2'b00} +: 4]];
endmodule

// File: rtl/data_bus.sv
// data_bus: data-side bus decoding RAM, LED, display, systick and timer registers.
// Timer (TH/TL/TCON, irq) is present only when PERIPH_TIMER_EN is defined.
module data_bus
  import data_bus_pkg::*;
#(
  parameter int RAM_DEPTH = 512,
  parameter int SCAN_DIV  = 100000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] MemBus_Address,
  input  logic [31:0] MemBus_Write_Data,
  output logic [31:0] Device_Read_Data,
  output logic [7:0]  leds,
  output logic [3:0]  an,
  output logic [7:0]  seg,
  output logic        irq
);
  localparam int AW = $clog2(RAM_DEPTH);
  logic [31:0] mem [RAM_DEPTH];
  logic [31:0] a, rd, th_q, tl_q, systick_q;
  logic [2:0]  tcon_q;
  logic [7:0]  led_q;
  logic [15:0] digits_q;
  logic        ram_hit, unused;
  assign a       = {MemBus_Address[31:2], 2'b00};
  assign unused  = &{1'b0, MemBus_Address[1:0]};
  assign ram_hit = MemBus_Address[31:AW+2] == '0;
  always_ff @(posedge clk)
    if (MemWrite && ram_hit) mem[MemBus_Address[AW+1:2]] <= MemBus_Write_Data;
  always_ff @(posedge clk)
    if (reset) begin
      led_q     <= '0;
      digits_q  <= '0;
      systick_q <= '0;
    end else begin
      systick_q <= systick_q + 1'b1;
      if (MemWrite && a == ADDR_LED)    led_q    <= MemBus_Write_Data[7:0];
      if (MemWrite && a == ADDR_DIGITS) digits_q <= MemBus_Write_Data[15:0];
    end
`ifdef PERIPH_TIMER_EN
  logic wr_th, wr_tl, wr_tcon, ovf;
  assign wr_th   = MemWrite && a == ADDR_TH;
  assign wr_tl   = MemWrite && a == ADDR_TL;
  assign wr_tcon = MemWrite && a == ADDR_TCON;
  assign ovf     = tcon_q[TCON_EN] && &tl_q;
  // Software writes win over the reload/increment and over the status set
  always_ff @(posedge clk)
    if (reset) begin
      th_q   <= '0;
      tl_q   <= '0;
      tcon_q <= '0;
    end else begin
      if (wr_th) th_q <= MemBus_Write_Data;
      tl_q <= wr_tl ? MemBus_Write_Data : ovf ? th_q : tcon_q[TCON_EN] ? tl_q + 1'b1 : tl_q;
      if (wr_tcon) tcon_q <= MemBus_Write_Data[2:0];
      else if (ovf && tcon_q[TCON_IE]) tcon_q[TCON_IS] <= 1'b1;
    end
`else
  assign th_q   = '0;
  assign tl_q   = '0;
  assign tcon_q = '0;
`endif
  assign irq  = tcon_q[TCON_IS];
  assign leds = led_q;
  always_comb begin
    rd = '0;
    if (ram_hit) rd = mem[MemBus_Address[AW+1:2]];
    else
      case (a)
        ADDR_TH:      rd = th_q;
        ADDR_TL:      rd = tl_q;
        ADDR_TCON:    rd = {29'd0, tcon_q};
        ADDR_LED:     rd = {24'd0, led_q};
        ADDR_DIGITS:  rd = {16'd0, digits_q};
        ADDR_SYSTICK: rd = systick_q;
        default:      rd = '0;
      endcase
    Device_Read_Data = MemRead ? rd : '0;
  end
  seg7_scan #(.SCAN_DIV(SCAN_DIV)) u_scan (
    .clk(clk),
    .reset(reset),
    .digits(digits_q),
    .an(an),
    .seg(seg)
  );
endmodule

// File: tb/tb_data_bus.sv
// tb_data_bus: directed checks of data_bus; timer tests follow PERIPH_TIMER_EN.
module tb_data_bus;
  logic        clk = 1'b0, reset, MemRead, MemWrite, irq;
  logic [31:0] addr, wdata, rdata, r;
  logic [7:0]  leds, seg;
  logic [3:0]  an;
  int errors = 0, checks = 0;
  always #5 clk = ~clk;
  data_bus #(.RAM_DEPTH(512), .SCAN_DIV(4)) dut (
    .clk(clk), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite),
    .MemBus_Address(addr), .MemBus_Write_Data(wdata), .Device_Read_Data(rdata),
    .leds(leds), .an(an), .seg(seg), .irq(irq)
  );
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    addr = a; wdata = d; MemWrite = 1'b1; MemRead = 1'b0;
    @(posedge clk);
    #1 MemWrite = 1'b0;
  endtask
  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    addr = a; MemRead = 1'b1;
    #1 d = rdata;
    MemRead = 1'b0;
  endtask
  task automatic test_reset;
    reset = 1'b1; MemRead = 1'b0; MemWrite = 1'b0; addr = '0; wdata = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    addr = 32'h4000_0014; MemRead = 1'b1;
    #1;
    checks++; if (leds !== 8'h00) begin errors++; $display("FAIL reset_leds got %h exp 00", leds); end
    checks++; if (an !== 4'b1110) begin errors++; $display("FAIL reset_an got %b exp 1110", an); end
    checks++; if (seg !== 8'hC0) begin errors++; $display("FAIL reset_seg got %h exp c0", seg); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq got %b exp 0", irq); end
    checks++; if (rdata !== 32'd0) begin errors++; $display("FAIL systick0 got %h exp 0", rdata); end
    @(posedge clk); #1;
    checks++; if (rdata !== 32'd1) begin errors++; $display("FAIL systick1 got %h exp 1", rdata); end
    MemRead = 1'b0;
  endtask
  task automatic test_ram;
    wr(32'h10, 32'hDEAD_BEEF);
    rd(32'h10, r);
    checks++; if (r !== 32'hDEAD_BEEF) begin errors++; $display("FAIL ram_rw got %h exp deadbeef", r); end
    wr(32'h0, 32'hA5A5_A5A5);
    wr(32'h7FC, 32'h0BAD_F00D);
    wr(32'h800, 32'h1234_5678);
    rd(32'h800, r);
    checks++; if (r !== 32'd0) begin errors++; $display("FAIL ram_oob got %h exp 0", r); end
    rd(32'h0, r);
    checks++; if (r !== 32'hA5A5_A5A5) begin errors++; $display("FAIL ram_noalias got %h exp a5a5a5a5", r); end
    rd(32'h7FF, r);
    checks++; if (r !== 32'h0BAD_F00D) begin errors++; $display("FAIL ram_last got %h exp 0badf00d", r); end
    addr = 32'h10; MemRead = 1'b0;
    #1;
    checks++; if (rdata !== 32'd0) begin errors++; $display("FAIL noread got %h exp 0", rdata); end
    rd(32'h4000_0018, r);
    checks++; if (r !== 32'd0) begin errors++; $display("FAIL unmapped got %h exp 0", r); end
  endtask
  task automatic test_led_overlap;
    wr(32'h4000_000C, 32'h0000_01A5);
    checks++; if (leds !== 8'hA5) begin errors++; $display("FAIL leds got %h exp a5", leds); end
    rd(32'h4000_000C, r);
    checks++; if (r !== 32'h0000_00A5) begin errors++; $display("FAIL led_read got %h exp a5", r); end
    @(negedge clk);
    addr = 32'h4000_000C; wdata = 32'h3C; MemRead = 1'b1; MemWrite = 1'b1;
    #1;
    checks++; if (rdata !== 32'h0000_00A5) begin errors++; $display("FAIL overlap_old got %h exp a5", rdata); end
    @(posedge clk);
    #1 MemWrite = 1'b0;
    #1;
    checks++; if (rdata !== 32'h0000_003C) begin errors++; $display("FAIL overlap_new got %h exp 3c", rdata); end
    MemRead = 1'b0;
  endtask
`ifdef PERIPH_TIMER_EN
  task automatic test_timer;
    wr(32'h4000_0000, 32'hFFFF_FFFC);
    wr(32'h4000_0004, 32'hFFFF_FFFC);
    wr(32'h4000_0008, 32'd3);
    repeat (3) @(posedge clk);
    #1;
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_early got %b exp 0", irq); end
    @(posedge clk); #1;
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_rise got %b exp 1", irq); end
    rd(32'h4000_0004, r);
    checks++; if (r !== 32'hFFFF_FFFC) begin errors++; $display("FAIL tl_reload got %h exp fffffffc", r); end
    rd(32'h4000_0008, r);
    checks++; if (r !== 32'd7) begin errors++; $display("FAIL tcon_is got %h exp 7", r); end
    wr(32'h4000_0008, 32'd1);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_clear got %b exp 0", irq); end
  endtask
  task automatic test_write_priority;
    wr(32'h4000_0008, 32'd0);
    wr(32'h4000_0000, 32'h100);
    wr(32'h4000_0004, 32'hFFFF_FFFE);
    wr(32'h4000_0008, 32'd3);
    @(posedge clk);
    wr(32'h4000_0004, 32'd5);
    rd(32'h4000_0004, r);
    checks++; if (r !== 32'd5) begin errors++; $display("FAIL tl_prio got %h exp 5", r); end
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_prio got %b exp 1", irq); end
    @(posedge clk); #1;
    rd(32'h4000_0004, r);
    checks++; if (r !== 32'd6) begin errors++; $display("FAIL tl_count got %h exp 6", r); end
  endtask
`else
  task automatic test_timer_off;
    wr(32'h4000_0000, 32'h1234);
    wr(32'h4000_0008, 32'd3);
    rd(32'h4000_0008, r);
    checks++; if (r !== 32'd0) begin errors++; $display("FAIL tcon_off got %h exp 0", r); end
    rd(32'h4000_0000, r);
    checks++; if (r !== 32'd0) begin errors++; $display("FAIL th_off got %h exp 0", r); end
    repeat (8) @(posedge clk);
    #1;
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_off got %b exp 0", irq); end
  endtask
`endif
  task automatic test_display;
    logic [7:0] seg_e [4];
    logic [3:0] prev;
    int n;
    seg_e[0] = 8'hC0; seg_e[1] = 8'hF9; seg_e[2] = 8'hA4; seg_e[3] = 8'hB0;
    wr(32'h4000_0010, 32'hABCD_3210);
    rd(32'h4000_0010, r);
    checks++; if (r !== 32'h0000_3210) begin errors++; $display("FAIL digits_read got %h exp 3210", r); end
    n = 0;
    do begin
      prev = an;
      @(posedge clk); #1;
      n++;
    end while (!(prev == 4'b0111 && an == 4'b1110) && n < 64);
    checks++; if (n >= 64) begin errors++; $display("FAIL scan_wrap got %0d cycles exp <64", n); end
    for (int d = 0; d < 4; d++)
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (an !== ~(4'b0001 << d)) begin errors++; $display("FAIL scan_an d%0d c%0d got %b exp %b", d, k, an, ~(4'b0001 << d)); end
        checks++;
        if (seg !== seg_e[d]) begin errors++; $display("FAIL scan_seg d%0d c%0d got %h exp %h", d, k, seg, seg_e[d]); end
        @(posedge clk); #1;
      end
  endtask
  initial begin
    test_reset;
    test_ram;
    test_led_overlap;
`ifdef PERIPH_TIMER_EN
    test_timer;
    test_write_priority;
`else
    test_timer_off;
`endif
    test_display;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
